gat_feat_reader: RTL and testbench
==================================

GAT_FEAT_READER -- requirements
Module: gat_feat_reader

Interface
REQ-001 SHALL have parameter NEW_FEATURE_WIDTH, default 32: width of one output feature word.
REQ-002 SHALL have parameter NEW_FEATURE_DEPTH, default 43328 (2708 x 16): number of words read out per run.
REQ-003 SHALL have parameter NUM_FEATURE_OUT, default 16: words per node row.
REQ-004 SHALL have parameter NEW_FEATURE_ADDR_W, default $clog2(NEW_FEATURE_DEPTH): word-address width.
REQ-005 SHALL have parameter RD_LATENCY, default 2: feature BRAM read latency in cycles.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4: output buffer depth, power of two, at least RD_LATENCY+1.
REQ-007 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-008 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-009 SHALL have port start, input, 1 bit: single-cycle pulse that requests a readout.
REQ-010 SHALL have port gat_ready, input, 1 bit: accelerator-finished flag.
REQ-011 SHALL have port feat_bram_addrb, output, NEW_FEATURE_ADDR_W+2 bits: byte address to the feature BRAM.
REQ-012 SHALL have port feat_bram_dout, input, NEW_FEATURE_WIDTH bits: BRAM read data.
REQ-013 SHALL have ports m_tdata (output, NEW_FEATURE_WIDTH), m_tvalid (output, 1), m_tready (input, 1) and m_tlast (output, 1): output stream.
REQ-014 SHALL have ports busy (output, 1), done (output, 1) and word_cnt (output, NEW_FEATURE_ADDR_W+1): status.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_RDY, STREAM, DRAIN and DONE.
REQ-016 SHALL move IDLE->WAIT_RDY on start=1; start in any other state SHALL be ignored.
REQ-017 SHALL move WAIT_RDY->STREAM on the first cycle gat_ready=1; while gat_ready=0 it SHALL remain in WAIT_RDY with no reads issued.
REQ-018 SHALL, in STREAM, issue one read per cycle with feat_bram_addrb = word_index*4 (bits [1:0]=0) only when occupancy + in-flight < FIFO_DEPTH.
REQ-019 SHALL track in-flight reads with a RD_LATENCY-deep valid shift register and write BRAM data into the FIFO exactly RD_LATENCY cycles after issue.
REQ-020 SHALL move STREAM->DRAIN after issuing word NEW_FEATURE_DEPTH-1, and DRAIN->DONE when in-flight=0, FIFO is empty and the last beat has handshaked.
REQ-021 SHALL pulse done for exactly one cycle while in DONE, then return to IDLE.
REQ-022 SHALL assert busy in WAIT_RDY, STREAM and DRAIN.
REQ-023 SHALL drive m_tvalid = FIFO non-empty, with m_tdata equal to the FIFO head.
REQ-024 SHALL pop the FIFO only when m_tvalid & m_tready; m_tdata SHALL stay stable while m_tvalid=1 and m_tready=0.
REQ-025 SHALL handle a simultaneous FIFO push and pop, including at full or empty, with no loss and no duplication.
REQ-026 SHALL increment word_cnt on each output handshake and clear it on an accepted start.
REQ-027 SHALL hold feat_bram_addrb at its last value when no read is issued.
REQ-028 SHALL continue the run to completion if gat_ready falls mid-STREAM.

Reset
REQ-029 SHALL, on rst_n=0 (asynchronous, including mid-run), enter IDLE and set m_tvalid=0, m_tlast=0, busy=0, done=0, word_cnt=0, feat_bram_addrb=0, FIFO empty and in-flight cleared.
REQ-030 SHALL discard BRAM data returning after reset deassertion from reads issued before reset.

Configuration
REQ-031 SHALL use macro FEAT_RD_ROW_LAST_EN to select m_tlast behaviour.
REQ-032 SHALL, with FEAT_RD_ROW_LAST_EN defined, assert m_tlast on every beat with (word_index mod NUM_FEATURE_OUT) = NUM_FEATURE_OUT-1.
REQ-033 SHALL, without FEAT_RD_ROW_LAST_EN, assert m_tlast only on word NEW_FEATURE_DEPTH-1.
REQ-034 SHALL carry m_tlast through the FIFO alongside its data in both configurations.

Verification
REQ-035 SHALL cover: NEW_FEATURE_DEPTH=32, m_tready=1, start with gat_ready=1 -> 32 beats matching BRAM contents; addrb sequence 0,4,...,124; done pulses once; word_cnt=32.
REQ-036 SHALL cover: start while gat_ready=0 for 10 cycles -> no addrb change and no m_tvalid until gat_ready rises.
REQ-037 SHALL cover: m_tready toggling 1/0 every cycle -> all 32 words in order, none lost or duplicated, occupancy never above FIFO_DEPTH.
REQ-038 SHALL cover: m_tready=0 for 20 cycles -> exactly FIFO_DEPTH reads outstanding/buffered, then the stream resumes in order.
REQ-039 SHALL cover: rst_n=0 mid-run at word 7 -> all outputs at reset values; a new start reads from addrb=0.
REQ-040 SHALL cover: FEAT_RD_ROW_LAST_EN defined with NUM_FEATURE_OUT=16 -> m_tlast on beats 15 and 31; undefined -> m_tlast on beat 31 only.

Source files
------------

// File: rtl/gat_feat_reader.sv
// Streams NEW_FEATURE_DEPTH feature words from a fixed-latency BRAM onto an AXI-Stream port.
// Build option FEAT_RD_ROW_LAST_EN: m_tlast marks every node-row end instead of only the final word.
module gat_feat_reader #(
  parameter int NEW_FEATURE_WIDTH  = 32,
  parameter int NEW_FEATURE_DEPTH  = 43328,
  parameter int NUM_FEATURE_OUT    = 16,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  parameter int RD_LATENCY         = 2,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          gat_ready,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
  output logic [NEW_FEATURE_WIDTH-1:0]  m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic                          busy,
  output logic                          done,
  output logic [NEW_FEATURE_ADDR_W:0]   word_cnt
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;
  localparam logic [NEW_FEATURE_ADDR_W-1:0] LAST_IDX = NEW_FEATURE_ADDR_W'(NEW_FEATURE_DEPTH - 1);
  localparam logic [CNT_W-1:0] FIFO_DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, WAIT_RDY, STREAM, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [NEW_FEATURE_ADDR_W-1:0] rd_idx;
  logic [NEW_FEATURE_ADDR_W+1:0] addr_hold;
  logic [CNT_W-1:0]              fifo_cnt, infl_cnt, occ_total;
  logic [PTR_W-1:0]              wr_ptr, rd_ptr;
  logic [RD_LATENCY-1:0]         vld_p, last_p;
  logic [NEW_FEATURE_WIDTH-1:0]  data_mem [FIFO_DEPTH];
  logic                          last_mem [FIFO_DEPTH];
  logic                          issue, issue_last, push, pop, start_acc;

  // Credit check counts reads already in flight so a stalled sink can never overflow the FIFO.
  assign occ_total = fifo_cnt + infl_cnt;
  assign issue     = (state == STREAM) && (occ_total < FIFO_DEPTH_C);
  assign push      = vld_p[RD_LATENCY-1];
  assign pop       = m_tvalid & m_tready;

  assign feat_bram_addrb = issue ? {rd_idx, 2'b00} : addr_hold;

`ifdef FEAT_RD_ROW_LAST_EN
  localparam int COL_W = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_FEATURE_OUT - 1);
  logic [COL_W-1:0] rd_col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_col <= '0;
    end else if (start_acc) begin
      rd_col <= '0;
    end else if (issue) begin
      rd_col <= (rd_col == LAST_COL) ? '0 : rd_col + COL_W'(1);
    end
  end

  assign issue_last = (rd_col == LAST_COL);
`else
  assign issue_last = (rd_idx == LAST_IDX);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = WAIT_RDY;
          start_acc = 1'b1;
        end
      end
      WAIT_RDY: if (gat_ready) state_nxt = STREAM;
      STREAM:   if (issue && (rd_idx == LAST_IDX)) state_nxt = DRAIN;
      DRAIN:    if ((infl_cnt == '0) && (fifo_cnt == '0)) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign busy = (state == WAIT_RDY) || (state == STREAM) || (state == DRAIN);
  assign done = (state == DONE);

  // Read issue: word index, held address and in-flight credit count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx    <= '0;
      addr_hold <= '0;
      infl_cnt  <= '0;
    end else begin
      if (start_acc)  rd_idx <= '0;
      else if (issue) rd_idx <= rd_idx + NEW_FEATURE_ADDR_W'(1);
      if (issue) addr_hold <= {rd_idx, 2'b00};
      case ({issue, push})
        2'b10:   infl_cnt <= infl_cnt + CNT_W'(1);
        2'b01:   infl_cnt <= infl_cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // BRAM latency stages: valid and tlast tag travel together; clearing vld_p drops pre-reset returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p <= '0;
    else        vld_p <= (vld_p << 1) | RD_LATENCY'(issue);
  end

  always_ff @(posedge clk) begin
    last_p <= (last_p << 1) | RD_LATENCY'(issue_last);
  end

  // Output FIFO: BRAM data lands here exactly RD_LATENCY cycles after issue.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= feat_bram_dout;
      last_mem[wr_ptr] <= last_p[RD_LATENCY-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      word_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: ;
      endcase
      if (start_acc) word_cnt <= '0;
      else if (pop)  word_cnt <= word_cnt + (NEW_FEATURE_ADDR_W+1)'(1);
    end
  end

  assign m_tvalid = (fifo_cnt != '0);
  assign m_tdata  = data_mem[rd_ptr];
  assign m_tlast  = m_tvalid & last_mem[rd_ptr];

endmodule

// File: tb/tb_gat_feat_reader.sv
// Directed bench for gat_feat_reader with a 32-word run and a latency-2 BRAM model.
module tb_gat_feat_reader;
  localparam int W     = 32;
  localparam int DEPTH = 32;
  localparam int NUM   = 16;
  localparam int AW    = $clog2(DEPTH);
  localparam int FD    = 4;

  logic          clk = 1'b0;
  logic          rst_n, start, gat_ready, m_tready;
  logic [AW+1:0] feat_bram_addrb;
  logic [W-1:0]  feat_bram_dout, m_tdata;
  logic          m_tvalid, m_tlast, busy, done;
  logic [AW:0]   word_cnt;

  int total = 0;
  int bad   = 0;
  int nbeat = 0;
  int done_cnt = 0;
  int addr_log[$];
  logic [AW+1:0] addr_last;
  logic          stall_prev = 1'b0;
  logic [W-1:0]  stall_data;
  logic [W-1:0]  d1, d2;

  gat_feat_reader #(
    .NEW_FEATURE_WIDTH(W),
    .NEW_FEATURE_DEPTH(DEPTH),
    .NUM_FEATURE_OUT(NUM),
    .RD_LATENCY(2),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .gat_ready(gat_ready),
    .feat_bram_addrb(feat_bram_addrb),
    .feat_bram_dout(feat_bram_dout),
    .m_tdata(m_tdata),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tlast(m_tlast),
    .busy(busy),
    .done(done),
    .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] exp_word(input int i);
    logic [7:0] lo;
    lo = i[7:0];
    return {8'hC3, lo, 16'(i * 97 + 5)};
  endfunction

  function automatic logic exp_last(input int i);
`ifdef FEAT_RD_ROW_LAST_EN
    return (i % NUM) == (NUM - 1);
`else
    return i == (DEPTH - 1);
`endif
  endfunction

  // Two-cycle BRAM: address sampled at an edge, data visible two edges later.
  always @(posedge clk) begin
    d1 <= exp_word(int'(feat_bram_addrb[AW+1:2]));
    d2 <= d1;
  end
  assign feat_bram_dout = d2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (feat_bram_addrb !== addr_last) begin
      addr_log.push_back(int'(feat_bram_addrb));
      addr_last = feat_bram_addrb;
    end
    if (rst_n) chk("fifo_bound", 64'(dut.fifo_cnt <= FD), 64'd1);
    if (stall_prev) begin
      chk("hold_valid", 64'(m_tvalid), 64'd1);
      chk("hold_data", 64'(m_tdata), 64'(stall_data));
    end
    stall_prev = m_tvalid && !m_tready;
    stall_data = m_tdata;
    if (m_tvalid && m_tready) begin
      chk("beat_data", 64'(m_tdata), 64'(exp_word(nbeat)));
      chk("beat_last", 64'(m_tlast), 64'(exp_last(nbeat)));
      nbeat++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic new_run();
    nbeat = 0;
    addr_log.delete();
    addr_log.push_back(int'(feat_bram_addrb));
    addr_last = feat_bram_addrb;
  endtask

  task automatic wait_done(input int budget, input bit toggle, input int drop_rdy_at);
    int c;
    int d0;
    c  = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && c < budget) begin
      tick();
      if (toggle) m_tready = ~m_tready;
      if (c == drop_rdy_at) gat_ready = 1'b0;
      c++;
    end
    chk("done_seen", 64'(done_cnt - d0), 64'd1);
    m_tready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tvalid"}, 64'(m_tvalid), 64'd0);
    chk({tag, "_tlast"}, 64'(m_tlast), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_word_cnt"}, 64'(word_cnt), 64'd0);
    chk({tag, "_addrb"}, 64'(feat_bram_addrb), 64'd0);
  endtask

  initial begin
    int c;
    rst_n = 1'b0; start = 1'b0; gat_ready = 1'b0; m_tready = 1'b1;
    addr_last = '0;
    repeat (3) tick();
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    // Plain run: full throughput
    gat_ready = 1'b1;
    new_run();
    done_cnt = 0;
    pulse_start();
    chk("busy_run", 64'(busy), 64'd1);
    wait_done(400, 1'b0, -1);
    chk("a_beats", 64'(nbeat), 64'd32);
    chk("a_word_cnt", 64'(word_cnt), 64'd32);
    chk("a_done_once", 64'(done_cnt), 64'd1);
    chk("a_busy_idle", 64'(busy), 64'd0);
    chk("a_addr_len", 64'(addr_log.size()), 64'd32);
    for (int i = 0; i < 32 && i < addr_log.size(); i++)
      chk("a_addr_seq", 64'(addr_log[i]), 64'(i * 4));

    // Start while the accelerator is not ready, then a back-pressured stream
    gat_ready = 1'b0;
    new_run();
    pulse_start();
    chk("b_word_cnt_clr", 64'(word_cnt), 64'd0);
    for (int i = 0; i < 10; i++) begin
      chk("b_wait_addrb", 64'(feat_bram_addrb), 64'd124);
      chk("b_wait_tvalid", 64'(m_tvalid), 64'd0);
      tick();
    end
    chk("b_busy_wait", 64'(busy), 64'd1);
    gat_ready = 1'b1;
    wait_done(600, 1'b1, 6);
    chk("b_beats", 64'(nbeat), 64'd32);
    chk("b_word_cnt", 64'(word_cnt), 64'd32);

    // Sink stalled for 20 cycles
    gat_ready = 1'b1;
    m_tready  = 1'b0;
    new_run();
    pulse_start();
    repeat (20) tick();
    chk("c_stall_tvalid", 64'(m_tvalid), 64'd1);
    chk("c_stall_data", 64'(m_tdata), 64'(exp_word(0)));
    chk("c_stall_addrb", 64'(feat_bram_addrb), 64'((FD - 1) * 4));
    chk("c_stall_fifo", 64'(dut.fifo_cnt), 64'(FD));
    chk("c_stall_word_cnt", 64'(word_cnt), 64'd0);
    m_tready = 1'b1;
    wait_done(400, 1'b0, -1);
    chk("c_beats", 64'(nbeat), 64'd32);

    // Reset in the middle of a run
    new_run();
    pulse_start();
    c = 0;
    while (word_cnt != 7 && c < 200) begin
      tick();
      c++;
    end
    chk("d_reach_word7", 64'(word_cnt), 64'd7);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("d_post_rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("d_post_rst_busy", 64'(busy), 64'd0);
    new_run();
    pulse_start();
    wait_done(400, 1'b0, -1);
    chk("d_beats", 64'(nbeat), 64'd32);
    chk("d_word_cnt", 64'(word_cnt), 64'd32);
    chk("d_addr_len", 64'(addr_log.size()), 64'd32);
    if (addr_log.size() >= 2) begin
      chk("d_addr0", 64'(addr_log[0]), 64'd0);
      chk("d_addr1", 64'(addr_log[1]), 64'd4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
